ram_rd_credit: RTL and testbench

//  Read-side controller that sits directly in front of the 256x16 RAM block, which has a fixed
//  RD_LATENCY-cycle read pipeline and no backpressure. It accepts burst read commands (start

---
 rtl/ram_rd_credit.sv | 213 +++++++++++++++++++++
 tb/tb_ram_rd_credit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rd_credit.sv
// ram_rd_credit
//   Read-side controller in front of a RAM with a fixed RD_LATENCY-cycle read
//   pipeline and no backpressure. Burst commands (start address + length-1)
//   are turned into one RAM read per cycle. Returned words land in a return
//   FIFO and are presented on a valid/ready stream with a last-word marker.
//   A credit counter limits reads in flight plus words buffered to FIFO_DEPTH,
//   so the return FIFO cannot overflow.
//
//   Ports
//     clk, aresetn          clock (rising edge), asynchronous active-low reset
//     cmd_valid/cmd_ready   burst command handshake
//     cmd_addr, cmd_len     first word address, burst length minus one
//     rd_addr, rd_read      RAM read address and read strobe
//     rd_data, rd_valid     RAM return data and valid
//     out_data, out_last    stream word and last-word-of-burst marker
//     out_valid, out_ready  stream handshake
//     busy                  command active, words outstanding, or flush running
//     err_ovf               sticky: a return word arrived while the FIFO was full
module ram_rd_credit #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 6,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [7:0]        cmd_len,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_read,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              err_ovf
);

   localparam int CRED_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FLUSH_W = $clog2(RD_LATENCY + 1);

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [7:0]          rem_reg, rem_next;
   logic [CRED_W-1:0]   credits_reg;
   logic [FLUSH_W-1:0]  flush_cnt_reg;
   logic [RD_LATENCY-1:0] last_pipe_reg;
   logic                issue_last;

   // Return FIFO: storage array plus a registered head (the out_* registers).
   logic [DATA_W:0]     fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [CRED_W-1:0]   mem_cnt_reg;
   logic [DATA_W-1:0]   out_data_reg;
   logic                out_last_reg;
   logic                out_valid_reg;
   logic                err_ovf_reg;

   logic flushing;
   logic pop;
   logic push;
   logic fifo_full;
   logic ovf;
   logic slot_free;
   logic load_from_mem;
   logic bypass;
   logic mem_wr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // ---------------------------------------------------------------------
   // Datapath control
   // ---------------------------------------------------------------------
   assign flushing = (flush_cnt_reg != '0);
   assign pop      = out_valid_reg & out_ready;
   assign push     = rd_valid & ~flushing;

   // Total occupancy counts the head register as one entry.
   assign fifo_full = out_valid_reg ? (mem_cnt_reg == CRED_W'(FIFO_DEPTH - 1))
                                    : (mem_cnt_reg == CRED_W'(FIFO_DEPTH));
   assign ovf       = push & fifo_full & ~pop;

   // The head register refills from storage first so word order is kept;
   // a return word goes straight to the head only when storage is empty.
   assign slot_free     = ~out_valid_reg | pop;
   assign load_from_mem = slot_free & (mem_cnt_reg != '0);
   assign bypass        = slot_free & (mem_cnt_reg == '0) & push;
   assign mem_wr        = push & ~bypass & ~ovf;

   // ---------------------------------------------------------------------
   // Command FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      rem_next   = rem_reg;
      cmd_ready  = 1'b0;
      rd_read    = 1'b0;
      issue_last = 1'b0;
      case (state_reg)
         IDLE: begin
            cmd_ready = ~flushing;
            if (cmd_valid && !flushing) begin
               addr_next  = cmd_addr;
               rem_next   = cmd_len;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (credits_reg != '0) begin
               rd_read   = 1'b1;
               addr_next = addr_reg + 1'b1;
               rem_next  = rem_reg - 8'd1;
               if (rem_reg == 8'd0) begin
                  issue_last = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         rem_reg       <= '0;
         credits_reg   <= CRED_W'(FIFO_DEPTH);
         flush_cnt_reg <= FLUSH_W'(RD_LATENCY);
         last_pipe_reg <= '0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         rem_reg   <= rem_next;
         if (flushing)
            flush_cnt_reg <= flush_cnt_reg - 1'b1;
         // A read consumes a credit, a pop returns one; both cancel.
         if (rd_read && !pop)
            credits_reg <= credits_reg - 1'b1;
         else if (!rd_read && pop)
            credits_reg <= credits_reg + 1'b1;
         // Last-word tag travels alongside the RAM read pipeline.
         last_pipe_reg[0] <= rd_read & issue_last;
         for (int i = 1; i < RD_LATENCY; i++)
            last_pipe_reg[i] <= last_pipe_reg[i-1];
      end
   end

   // ---------------------------------------------------------------------
   // Return FIFO
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (mem_wr)
         fifo_mem[wr_ptr_reg] <= {last_pipe_reg[RD_LATENCY-1], rd_data};
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         mem_cnt_reg   <= '0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         err_ovf_reg   <= 1'b0;
      end else begin
         if (load_from_mem) begin
            out_data_reg  <= fifo_mem[rd_ptr_reg][DATA_W-1:0];
            out_last_reg  <= fifo_mem[rd_ptr_reg][DATA_W];
            out_valid_reg <= 1'b1;
            rd_ptr_reg    <= ptr_inc(rd_ptr_reg);
         end else if (bypass) begin
            out_data_reg  <= rd_data;
            out_last_reg  <= last_pipe_reg[RD_LATENCY-1];
            out_valid_reg <= 1'b1;
         end else if (pop) begin
            out_valid_reg <= 1'b0;
         end

         if (mem_wr)
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);

         if (mem_wr && !load_from_mem)
            mem_cnt_reg <= mem_cnt_reg + 1'b1;
         else if (!mem_wr && load_from_mem)
            mem_cnt_reg <= mem_cnt_reg - 1'b1;

         if (ovf)
            err_ovf_reg <= 1'b1;
      end
   end

   assign rd_addr   = addr_reg;
   assign out_data  = out_data_reg;
   assign out_last  = out_last_reg;
   assign out_valid = out_valid_reg;
   assign err_ovf   = err_ovf_reg;
   assign busy      = (state_reg != IDLE) | (credits_reg != CRED_W'(FIFO_DEPTH)) | flushing;

endmodule

// File: tb/tb_ram_rd_credit.sv
// tb_ram_rd_credit
//   Bench for ram_rd_credit. A behavioural RAM with a fixed read latency feeds
//   the design; a reference model (word queue, outstanding-read count, flush
//   timer) predicts every cycle's handshakes and every stream word.
`timescale 1ns/1ps
module tb_ram_rd_credit;
   localparam int AW    = 8;
   localparam int DW    = 16;
   localparam int LAT   = 6;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          aresetn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr;
   logic [7:0]    cmd_len;
   logic [AW-1:0] rd_addr;
   logic          rd_read;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          err_ovf;

   always #5 clk = ~clk;

   ram_rd_credit #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .rd_addr(rd_addr), .rd_read(rd_read), .rd_data(rd_data), .rd_valid(rd_valid),
      .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .err_ovf(err_ovf)
   );

   // Behavioural RAM: fixed latency, not affected by the controller's reset.
   logic [DW-1:0]  ram [256];
   logic [LAT-1:0] pv = '0;
   logic [DW-1:0]  pd [LAT];
   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], rd_read};
      pd[0] <= ram[rd_addr];
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end
   assign rd_valid = pv[LAT-1];
   assign rd_data  = pd[LAT-1];

   // Reference model
   typedef struct packed { logic [DW-1:0] d; logic l; } word_t;
   word_t        exp_q[$];
   logic [AW-1:0] addr_log[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  since_rst = 0;
   bit  issuing = 0;
   int  left = 0;
   logic [AW-1:0] exp_addr = '0;
   int  outstanding = 0;
   int  n_reads = 0, n_pops = 0;
   int  t_rd = -1, t_ov = -1, first_pop = -1, last_pop = -1;
   bit  last_acc = 0;
   bit  rnd_ready = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check at the falling edge, advance the model, return
   // 1ns after the rising edge so the caller can drive new inputs.
   task automatic cycle();
      bit    exp_rd;
      bit    acc;
      word_t w;
      @(negedge clk);
      last_acc = 0;
      if (!aresetn) begin
         chk("rst_cmd_ready", cmd_ready, 0);
         chk("rst_rd_read",   rd_read,   0);
         chk("rst_rd_addr",   rd_addr,   0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_last",  out_last,  0);
         chk("rst_out_data",  out_data,  0);
         chk("rst_busy",      busy,      1);
         chk("rst_err_ovf",   err_ovf,   0);
      end else begin
         exp_rd = issuing && (outstanding < DEPTH);
         acc    = cmd_valid && !issuing && (since_rst >= LAT);
         chk("rd_read", rd_read, exp_rd);
         if (exp_rd) chk("rd_addr", rd_addr, exp_addr);
         chk("cmd_ready", cmd_ready, !issuing && (since_rst >= LAT));
         chk("busy", busy, issuing || (outstanding != 0) || (since_rst < LAT));
         chk("err_ovf", err_ovf, 0);
         if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 0);
         if (rd_read) begin
            n_reads++;
            addr_log.push_back(rd_addr);
            if (t_rd < 0) t_rd = cyc;
         end
         if (out_valid && t_ov < 0) t_ov = cyc;
         if (out_valid && out_ready && exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("out_data", out_data, w.d);
            chk("out_last", out_last, w.l);
            outstanding--;
            n_pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
         if (exp_rd) begin
            exp_addr++;
            left--;
            outstanding++;
            if (left == 0) issuing = 0;
         end
         if (acc) begin
            last_acc = 1;
            issuing  = 1;
            left     = int'(cmd_len) + 1;
            exp_addr = cmd_addr;
            for (int i = 0; i <= int'(cmd_len); i++) begin
               w.d = ram[8'(int'(cmd_addr) + i)];
               w.l = (i == int'(cmd_len));
               exp_q.push_back(w);
            end
         end
      end
      @(posedge clk);
      cyc++;
      if (aresetn) since_rst++; else since_rst = 0;
      #1;
   endtask

   task automatic send(input logic [AW-1:0] a, input logic [7:0] l);
      cmd_valid = 1; cmd_addr = a; cmd_len = l;
      for (int k = 0; k < 600; k++) begin
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
         cycle();
         if (last_acc) break;
      end
      chk("cmd_accept_timeout", last_acc, 1);
      cmd_valid = 0;
   endtask

   task automatic drain();
      for (int k = 0; k < 3000; k++) begin
         if (exp_q.size() == 0 && !issuing) break;
         if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      chk("drain_left", exp_q.size(), 0);
      // Let the credit return settle so busy is seen low.
      out_ready = 1;
      cycle();
   endtask

   task automatic do_reset(input int n);
      aresetn = 0;
      exp_q.delete();
      issuing = 0; left = 0; outstanding = 0; since_rst = 0;
      for (int k = 0; k < n; k++) cycle();
      aresetn = 1;
   endtask

   logic [AW-1:0] t4_exp [4];

   initial begin
      cmd_valid = 0; cmd_addr = '0; cmd_len = '0; out_ready = 1;
      for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
      #1;
      do_reset(3);

      // 1: single word, latency
      ram[8'h10] = 16'hBEEF;
      t_rd = -1; t_ov = -1;
      send(8'h10, 8'd0);
      drain();
      chk("t1_latency", t_ov - t_rd, 7);
      $display("T1 single word latency=%0d", t_ov - t_rd);

      // 2: 16-word burst at full rate
      for (int i = 0; i < 16; i++) ram[i] = 16'(i);
      n_reads = 0; first_pop = -1; last_pop = -1;
      send(8'h00, 8'd15);
      drain();
      chk("t2_reads", n_reads, 16);
      chk("t2_pop_span", last_pop - first_pop, 15);
      $display("T2 16-word burst reads=%0d span=%0d", n_reads, last_pop - first_pop);

      // 3: stalled consumer, credits cap reads at FIFO depth
      for (int i = 0; i < 32; i++) ram[i] = 16'(16'h0100 + i);
      n_reads = 0;
      out_ready = 0;
      send(8'h00, 8'd31);
      for (int k = 0; k < 30; k++) cycle();
      chk("t3_stall_reads", n_reads, DEPTH);
      out_ready = 1;
      drain();
      chk("t3_total_reads", n_reads, 32);
      $display("T3 stalled burst reads=%0d", n_reads);

      // 4: address wrap
      addr_log.delete();
      t4_exp[0] = 8'hFE; t4_exp[1] = 8'hFF; t4_exp[2] = 8'h00; t4_exp[3] = 8'h01;
      send(8'hFE, 8'd3);
      drain();
      chk("t4_nreads", addr_log.size(), 4);
      for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("t4_addr", addr_log[i], t4_exp[i]);
      $display("T4 wrap burst reads=%0d", addr_log.size());

      // 5: back-to-back commands, random consumer
      rnd_ready = 1; n_pops = 0;
      send(8'h40, 8'd2);
      send(8'h80, 8'd1);
      drain();
      chk("t5_pops", n_pops, 5);
      $display("T5 back-to-back pops=%0d", n_pops);

      // 6: reset in the middle of a burst
      rnd_ready = 0; out_ready = 1; n_pops = 0;
      send(8'h20, 8'd9);
      for (int k = 0; k < 200 && n_pops < 4; k++) cycle();
      chk("t6_pre_reset_pops", n_pops, 4);
      #2;
      do_reset(2);
      n_pops = 0;
      send(8'h30, 8'd4);
      drain();
      chk("t6_post_pops", n_pops, 5);
      $display("T6 reset mid-burst, post pops=%0d", n_pops);

      // 7: random commands against the model
      rnd_ready = 1;
      for (int t = 0; t < 8; t++) begin
         send(8'($urandom), 8'($urandom_range(0, 40)));
         $display("T7 random command %0d accepted", t);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
